// File: rtl/hs_tx_port_if.sv
`default_nettype none
// ============================================================================
//  Module      : hs_tx_port_if
//  Description : Host-write and processor-handshake signal bundle for
//                hs_tx_port. The master side is the host writer plus the
//                processor request/acknowledge pins; the slave side is the
//                port itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hs_tx_port_if #(
  parameter int DEPTH = 4
) ();
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             wr_en;
  logic [7:0]       wr_data;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underrun;
  logic             clr_flags;
  logic             hs_req;
  logic             hs_ack;
  logic [7:0]       proc_data;
  logic             busy;
  logic             xfer_done;

  modport master (
    output wr_en, wr_data, clr_flags, hs_req,
    input  full, empty, count, overflow, underrun,
    input  hs_ack, proc_data, busy, xfer_done
  );

  modport slave (
    input  wr_en, wr_data, clr_flags, hs_req,
    output full, empty, count, overflow, underrun,
    output hs_ack, proc_data, busy, xfer_done
  );
endinterface
`default_nettype wire

// File: rtl/hs_tx_port.sv
`default_nettype none
// ============================================================================
//  Module      : hs_tx_port
//  Description : Byte source for the processor's 8-bit input handshake.
//                Host bytes are queued in a small circular FIFO; each
//                processor request is answered with a four-phase req/ack
//                exchange presenting the FIFO head on proc_data.
//  Revision    : 1.0 - initial release
// ============================================================================
module hs_tx_port #(
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 1,
  parameter int TIMEOUT   = 255
) (
  input  wire logic   g_clk,
  input  wire logic   g_clr,
  hs_tx_port_if.slave bus
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_SC_W  = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

  localparam logic [c_SC_W-1:0]  c_SETUP_LAST = c_SC_W'(SETUP_CYC - 1);
  localparam logic [7:0]         c_TIMEOUT    = 8'(TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_DEPTH      = c_CNT_W'(DEPTH);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_SETUP = 2'd1;
  localparam logic [1:0] c_ST_ACK   = 2'd2;

  // FIFO storage and bookkeeping
  logic [7:0]         mem_q [DEPTH];
  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0] count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;

  // Handshake FSM state
  logic [1:0]         state_q, state_d;
  logic [c_SC_W-1:0]  setup_cnt_q, setup_cnt_d;
  logic [7:0]         wait_cnt_q, wait_cnt_d;
  logic               hs_ack_q, hs_ack_d;
  logic [7:0]         proc_data_q, proc_data_d;
  logic               busy_q, busy_d;
  logic               xfer_done_q, xfer_done_d;

  // Sticky flags
  logic               overflow_q, overflow_d;
  logic               underrun_q, underrun_d;

  logic               w_push;
  logic               w_pop;
  logic               w_underrun_evt;

  // Full is judged on the registered state, so a write in the same cycle
  // as a pop from a full FIFO is still dropped.
  assign w_push = bus.wr_en & ~full_q;

  // Handshake FSM: present head, hold for setup, ack, pop on req release
  always_comb begin
    state_d        = state_q;
    setup_cnt_d    = setup_cnt_q;
    wait_cnt_d     = 8'd0;
    hs_ack_d       = hs_ack_q;
    proc_data_d    = proc_data_q;
    xfer_done_d    = 1'b0;
    w_pop          = 1'b0;
    w_underrun_evt = 1'b0;

    case (state_q)
      c_ST_IDLE: begin
        hs_ack_d = 1'b0;
        if (bus.hs_req && !empty_q) begin
          proc_data_d = mem_q[rd_ptr_q];
          setup_cnt_d = '0;
          state_d     = c_ST_SETUP;
        end else if (bus.hs_req) begin
          wait_cnt_d = (wait_cnt_q == c_TIMEOUT) ? c_TIMEOUT
                                                 : 8'(wait_cnt_q + 8'd1);
          if (wait_cnt_d == c_TIMEOUT) begin
            w_underrun_evt = 1'b1;
          end
        end
      end

      c_ST_SETUP: begin
        if (!bus.hs_req) begin
          // Request withdrawn before ack: nothing consumed.
          state_d = c_ST_IDLE;
        end else if (setup_cnt_q == c_SETUP_LAST) begin
          state_d  = c_ST_ACK;
          hs_ack_d = 1'b1;
        end else begin
          setup_cnt_d = c_SC_W'(setup_cnt_q + 1'b1);
        end
      end

      c_ST_ACK: begin
        if (!bus.hs_req) begin
          hs_ack_d    = 1'b0;
          w_pop       = 1'b1;
          xfer_done_d = 1'b1;
          state_d     = c_ST_IDLE;
        end
      end

      default: begin
        state_d  = c_ST_IDLE;
        hs_ack_d = 1'b0;
      end
    endcase

    busy_d = (state_d != c_ST_IDLE);
  end

  // FIFO pointer, occupancy and status next-state
  always_comb begin
    wr_ptr_d = w_push ? c_PTR_W'(wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = w_pop  ? c_PTR_W'(rd_ptr_q + 1'b1) : rd_ptr_q;
    case ({w_push, w_pop})
      2'b10:   count_d = c_CNT_W'(count_q + 1'b1);
      2'b01:   count_d = c_CNT_W'(count_q - 1'b1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == c_DEPTH);
    empty_d = (count_d == '0);
  end

  // Sticky flags: a new event in the same cycle as clr_flags wins
  always_comb begin
    overflow_d = overflow_q;
    underrun_d = underrun_q;
    if (bus.clr_flags) begin
      overflow_d = 1'b0;
      underrun_d = 1'b0;
    end
    if (bus.wr_en && full_q) begin
      overflow_d = 1'b1;
    end
    if (w_underrun_evt) begin
      underrun_d = 1'b1;
    end
  end

  // FIFO storage write; contents need no reset since reads are gated by count
  always_ff @(posedge g_clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  // State registers; reset asynchronously drops ack and flushes the FIFO
  always_ff @(posedge g_clk or posedge g_clr) begin
    if (g_clr) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      state_q     <= c_ST_IDLE;
      setup_cnt_q <= '0;
      wait_cnt_q  <= 8'd0;
      hs_ack_q    <= 1'b0;
      proc_data_q <= 8'h00;
      busy_q      <= 1'b0;
      xfer_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      hs_ack_q    <= hs_ack_d;
      proc_data_q <= proc_data_d;
      busy_q      <= busy_d;
      xfer_done_q <= xfer_done_d;
      overflow_q  <= overflow_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.underrun  = underrun_q;
  assign bus.hs_ack    = hs_ack_q;
  assign bus.proc_data = proc_data_q;
  assign bus.busy      = busy_q;
  assign bus.xfer_done = xfer_done_q;

endmodule
`default_nettype wire

// File: tb/tb_hs_tx_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hs_tx_port
//  Description : Directed bench for hs_tx_port. Accepted host bytes are
//                queued as expected presentations; a monitor compares
//                proc_data against the queue head on every ack rise.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_tx_port;

  localparam int DEPTH     = 4;
  localparam int SETUP_CYC = 3;
  localparam int TIMEOUT   = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hs_tx_port_if #(.DEPTH(DEPTH)) bus ();

  hs_tx_port #(
    .DEPTH     (DEPTH),
    .SETUP_CYC (SETUP_CYC),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .g_clk (clk),
    .g_clr (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic       ack_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Host write; bytes expected to be accepted are queued for the monitor
  task automatic write_byte(input logic [7:0] b, input bit accepted);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    if (accepted) exp_q.push_back(b);
    tick(1);
    bus.wr_en   = 1'b0;
  endtask

  task automatic handshake(input string name);
    int k;
    bus.hs_req = 1'b1;
    k = 0;
    tick(1);
    while (!bus.hs_ack && k < 20) begin
      tick(1);
      k++;
    end
    check({name, "_ack_hi"}, {31'd0, bus.hs_ack}, 32'd1);
    bus.hs_req = 1'b0;
    tick(1);
    check({name, "_ack_lo"}, {31'd0, bus.hs_ack}, 32'd0);
    check({name, "_xfer_done"}, {31'd0, bus.xfer_done}, 32'd1);
    tick(1);
  endtask

  // Monitor: every ack rise must present the oldest outstanding byte
  always @(negedge clk) begin
    if (!rst && bus.hs_ack && !ack_prev) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL ack_unexpected: got data %0h, expected no ack", bus.proc_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.proc_data !== e) begin
          n_err++;
          $display("FAIL ack_data: got %0h, expected %0h", bus.proc_data, e);
        end
      end
    end
    ack_prev = bus.hs_ack;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.wr_en     = 1'b0;
    bus.wr_data   = 8'h00;
    bus.clr_flags = 1'b0;
    bus.hs_req    = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Reset state
    check("rst_ack",   {31'd0, bus.hs_ack},    32'd0);
    check("rst_data",  {24'd0, bus.proc_data}, 32'h00);
    check("rst_busy",  {31'd0, bus.busy},      32'd0);
    check("rst_xfer",  {31'd0, bus.xfer_done}, 32'd0);
    check("rst_ovf",   {31'd0, bus.overflow},  32'd0);
    check("rst_und",   {31'd0, bus.underrun},  32'd0);
    check("rst_count", {29'd0, bus.count},     32'd0);
    check("rst_empty", {31'd0, bus.empty},     32'd1);
    check("rst_full",  {31'd0, bus.full},      32'd0);

    // Single transfer with setup timing
    write_byte(8'hA5, 1'b1);
    check("t1_count1", {29'd0, bus.count}, 32'd1);
    check("t1_empty",  {31'd0, bus.empty}, 32'd0);
    bus.hs_req = 1'b1;
    tick(1);
    check("t1_data",   {24'd0, bus.proc_data}, 32'hA5);
    check("t1_busy",   {31'd0, bus.busy},      32'd1);
    tick(SETUP_CYC - 1);
    check("t1_ack_early", {31'd0, bus.hs_ack}, 32'd0);
    tick(1);
    check("t1_ack", {31'd0, bus.hs_ack}, 32'd1);
    bus.hs_req = 1'b0;
    tick(1);
    check("t1_ack_drop", {31'd0, bus.hs_ack},    32'd0);
    check("t1_xfer",     {31'd0, bus.xfer_done}, 32'd1);
    check("t1_count0",   {29'd0, bus.count},     32'd0);
    tick(1);
    check("t1_xfer_pulse", {31'd0, bus.xfer_done}, 32'd0);
    check("t1_idle",       {31'd0, bus.busy},      32'd0);

    // Fill, overflow, ordered drain, pointer wrap
    for (int i = 1; i <= 4; i++) write_byte(8'(i), 1'b1);
    check("t2_full",  {31'd0, bus.full},  32'd1);
    check("t2_count", {29'd0, bus.count}, 32'd4);
    write_byte(8'h05, 1'b0);
    check("t2_ovf",       {31'd0, bus.overflow}, 32'd1);
    check("t2_count_ovf", {29'd0, bus.count},    32'd4);
    for (int i = 0; i < 4; i++) handshake("t2_hs");
    check("t2_empty", {31'd0, bus.empty}, 32'd1);
    write_byte(8'h10, 1'b1);
    handshake("t2_wrap");
    bus.clr_flags = 1'b1;
    tick(1);
    bus.clr_flags = 1'b0;
    check("t2_ovf_clr", {31'd0, bus.overflow}, 32'd0);

    // Underrun after TIMEOUT edges of unserved request
    bus.hs_req = 1'b1;
    tick(TIMEOUT - 1);
    check("t3_und_early", {31'd0, bus.underrun}, 32'd0);
    tick(1);
    check("t3_und",     {31'd0, bus.underrun}, 32'd1);
    check("t3_no_ack",  {31'd0, bus.hs_ack},   32'd0);
    write_byte(8'h3C, 1'b1);
    check("t3_old_data", {24'd0, bus.proc_data}, 32'h10);
    tick(1);
    check("t3_data", {24'd0, bus.proc_data}, 32'h3C);
    handshake("t3_hs");
    bus.clr_flags = 1'b1;
    tick(1);
    bus.clr_flags = 1'b0;
    check("t3_und_clr", {31'd0, bus.underrun}, 32'd0);

    // Write to a full FIFO on the same edge as the ack-exit pop
    for (int i = 1; i <= 4; i++) write_byte(8'hA0 + 8'(i), 1'b1);
    bus.hs_req = 1'b1;
    for (int k = 0; k < 20 && !bus.hs_ack; k++) tick(1);
    check("t4_ack", {31'd0, bus.hs_ack}, 32'd1);
    bus.hs_req  = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hEE;
    tick(1);
    bus.wr_en   = 1'b0;
    check("t4_ovf",   {31'd0, bus.overflow},  32'd1);
    check("t4_count", {29'd0, bus.count},     32'd3);
    check("t4_xfer",  {31'd0, bus.xfer_done}, 32'd1);
    for (int i = 0; i < 3; i++) handshake("t4_drain");
    check("t4_empty", {31'd0, bus.empty}, 32'd1);
    bus.clr_flags = 1'b1;
    tick(1);
    bus.clr_flags = 1'b0;

    // Asynchronous reset mid-handshake
    write_byte(8'hB1, 1'b1);
    write_byte(8'hB2, 1'b1);
    bus.hs_req = 1'b1;
    for (int k = 0; k < 20 && !bus.hs_ack; k++) tick(1);
    check("t5_ack",   {31'd0, bus.hs_ack}, 32'd1);
    tick(1);
    check("t5_count2", {29'd0, bus.count}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("t5_ack_rst",   {31'd0, bus.hs_ack}, 32'd0);
    check("t5_count_rst", {29'd0, bus.count},  32'd0);
    check("t5_empty_rst", {31'd0, bus.empty},  32'd1);
    exp_q.delete();
    bus.hs_req = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    bus.hs_req = 1'b1;
    tick(10);
    check("t5_no_ack",  {31'd0, bus.hs_ack}, 32'd0);
    check("t5_no_busy", {31'd0, bus.busy},   32'd0);
    bus.hs_req = 1'b0;
    tick(1);

    // Request withdrawn during setup
    write_byte(8'hC7, 1'b1);
    bus.hs_req = 1'b1;
    tick(1);
    check("t6_busy", {31'd0, bus.busy}, 32'd1);
    tick(1);
    check("t6_ack_setup", {31'd0, bus.hs_ack}, 32'd0);
    bus.hs_req = 1'b0;
    tick(1);
    check("t6_ack",   {31'd0, bus.hs_ack},    32'd0);
    check("t6_idle",  {31'd0, bus.busy},      32'd0);
    check("t6_count", {29'd0, bus.count},     32'd1);
    check("t6_xfer",  {31'd0, bus.xfer_done}, 32'd0);
    tick(2);
    handshake("t6_hs");
    check("t6_count0", {29'd0, bus.count}, 32'd0);

    tick(2);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d bytes unpresented, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
